// File: rtl/match_det_pkg.sv
// Shared types and helpers for the masked pattern detectors.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package match_det_pkg;

    localparam int RUN_W = 8;
    // Widest sample the masked compare accepts; narrower callers zero-extend.
    localparam int MAX_W = 64;

    typedef struct packed {
        logic v;
        logic m;
        logic d;
    } stage_t;

    // Zero-extended mask bits are don't-care, so narrower operands compare correctly.
    function automatic logic masked_match(
        input logic [MAX_W-1:0] smp,
        input logic [MAX_W-1:0] pat,
        input logic [MAX_W-1:0] mask
    );
        return ((smp ^ pat) & mask) == '0;
    endfunction

endpackage

// File: rtl/match_stats.sv
// Match statistics: saturating hit counter, sticky flag, run-length qualifier.
// Latency: registered, one cycle after the event on hit/v.
// Backpressure: none; an event is accepted every cycle.
module match_stats
    import match_det_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int RUN_MIN = 1
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             hit,
    input  logic             v,
    input  logic             clr,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             sticky,
    output logic             run_hit
);

    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(RUN_MIN);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             sticky_d, sticky_q;
    logic [RUN_W-1:0] run_d, run_q;
    logic             run_hit_d, run_hit_q;

    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        run_d    = run_q;
        if (clr) begin
            // clear beats a coincident hit
            cnt_d    = '0;
            sticky_d = 1'b0;
            run_d    = '0;
        end else if (hit) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
            sticky_d = 1'b1;
            if (run_q < RUN_SAT) begin
                run_d = run_q + 1'b1;
            end
        end else if (v) begin
            run_d = '0;
        end
        run_hit_d = (run_d >= RUN_SAT);
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            run_q     <= '0;
            run_hit_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sticky_q  <= sticky_d;
            run_q     <= run_d;
            run_hit_q <= run_hit_d;
        end
    end

    assign hit_cnt = cnt_q;
    assign sticky  = sticky_q;
    assign run_hit = run_hit_q;

endmodule

// File: rtl/pipe_match_det.sv
// Masked pattern detector with a DELAY-deep output pipe and match statistics.
// Latency: DELAY cycles din->dout; statistics one cycle later.
// Backpressure: none; one sample per cycle, always accepted.
module pipe_match_det
    import match_det_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int DELAY   = 4,
    parameter int CNT_W   = 8,
    parameter int RUN_MIN = 1
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             din_vld,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] pat,
    input  logic [WIDTH-1:0] mask,
    input  logic             inv,
    input  logic             clr,
    output logic             dout,
    output logic             dout_vld,
    output logic             run_hit,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             sticky
);

    stage_t s1_d;
    stage_t last;
    logic   m_c;

    // Polarity is folded in at capture, so in-flight samples keep their old evaluation.
    always_comb begin
        m_c    = din_vld & masked_match(MAX_W'(din), MAX_W'(pat), MAX_W'(mask));
        s1_d.v = din_vld;
        s1_d.m = m_c;
        s1_d.d = din_vld & (m_c ^ inv);
    end

    for (genvar i = 0; i < DELAY; i++) begin : g_pipe
        stage_t stg_d;
        stage_t stg_q;

        if (i == 0) begin : g_first
            always_comb stg_d = s1_d;
        end else begin : g_next
            always_comb stg_d = g_pipe[i-1].stg_q;
        end

        always_ff @(posedge sclk or posedge rst) begin
            if (rst) begin
                stg_q <= '0;
            end else begin
                stg_q <= stg_d;
            end
        end
    end

    assign last     = g_pipe[DELAY-1].stg_q;
    assign dout     = last.d;
    assign dout_vld = last.v;

    match_stats #(
        .CNT_W  (CNT_W),
        .RUN_MIN(RUN_MIN)
    ) u_stats (
        .sclk   (sclk),
        .rst    (rst),
        .hit    (last.v & last.m),
        .v      (last.v),
        .clr    (clr),
        .hit_cnt(hit_cnt),
        .sticky (sticky),
        .run_hit(run_hit)
    );

endmodule
